carfield_l2_dual_port_sched: RTL and testbench

- Request scheduler in front of the two interleaved L2 ports: port 0 at 0x7800_0000 and port 1 at 0x7820_0000, 2 MiB each.
- Decodes each requester's address to its L2 port and round-robin arbitrates per port, so both ports serve different requesters in the same cycle.
- Tracks outstanding reads and writes per port, routes in-order port responses back to the issuing requester, and answers out-of-range accesses with an error.
- Sits between the host/DMA memory-request masters and the two L2 port adapters.

---
 rtl/carfield_l2_sched_pkg.sv | 19 +
 rtl/carfield_l2_sched_port.sv | 65 ++++++
 rtl/carfield_l2_dual_port_sched.sv | 132 +++++++++++++
 tb/tb_carfield_l2_dual_port_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/carfield_l2_sched_pkg.sv
// Shared types and address decode for the Carfield dual-port L2 request scheduler.
package carfield_l2_sched_pkg;

  typedef enum logic [1:0] {L2P0, L2P1, L2ERR} l2_port_e;

  localparam logic [63:0] L2Port0BaseDefault = 64'h7800_0000;
  localparam logic [63:0] L2PortSizeDefault  = 64'h0020_0000;
  localparam logic [63:0] L2Port1Base        = L2Port0BaseDefault + L2PortSizeDefault;
  localparam int unsigned L2OffsetWidth      = $clog2(L2PortSizeDefault);

  function automatic l2_port_e port_decode(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] size);
    if (addr >= base && addr < base + size) return L2P0;
    if (addr >= base + size && addr < base + (size << 1)) return L2P1;
    return L2ERR;
  endfunction

endpackage

// File: rtl/carfield_l2_sched_port.sv
// One L2 port: round-robin arbiter over eligible requesters plus the in-order ID FIFO.
module carfield_l2_sched_port #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdW           = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] elig_i,
  input  logic              gnt_i,
  input  logic              rvalid_i,
  output logic              req_o,
  output logic [IdW-1:0]    winner_o,
  output logic              hs_o,
  output logic              pop_o,
  output logic [IdW-1:0]    head_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]  ptr_q;
  logic [IdW-1:0]  mem_q [MaxOutstanding];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;
  logic            found, full;
  logic [IdW-1:0]  idx;

  always_comb begin
    found    = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = IdW'((32'(ptr_q) + i) % NumReq);
      if (!found && elig_i[idx]) begin
        found    = 1'b1;
        winner_o = idx;
      end
    end
  end

  assign full   = (cnt_q == CntW'(MaxOutstanding));
  assign req_o  = found && !full;
  assign hs_o   = req_o && gnt_i;
  assign pop_o  = rvalid_i && (cnt_q != '0);
  assign head_o = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (hs_o) begin
        mem_q[wr_q] <= winner_o;
        wr_q        <= wr_q + 1'b1;
        ptr_q       <= (winner_o == IdW'(NumReq - 1)) ? '0 : winner_o + 1'b1;
      end
      if (pop_o) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CntW'(hs_o) - CntW'(pop_o);
    end
  end

endmodule

// File: rtl/carfield_l2_dual_port_sched.sv
// Decodes requester addresses onto the two interleaved L2 ports, arbitrates per port,
// answers out-of-range accesses from a single-slot error path and routes responses back.
module carfield_l2_dual_port_sched
  import carfield_l2_sched_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter logic [63:0] L2Port0Base    = 64'h7800_0000,
  parameter logic [63:0] L2PortSize     = 64'h0020_0000,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned OffW          = $clog2(L2PortSize),
  localparam int unsigned BeW           = DataWidth / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]           req_we_i,
  input  logic [NumReq*DataWidth-1:0] req_wdata_i,
  input  logic [NumReq*BeW-1:0]       req_be_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic [DataWidth-1:0]        rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic [1:0]                  l2_req_o,
  input  logic [1:0]                  l2_gnt_i,
  output logic [2*OffW-1:0]           l2_addr_o,
  output logic [1:0]                  l2_we_o,
  output logic [2*DataWidth-1:0]      l2_wdata_o,
  output logic [2*BeW-1:0]            l2_be_o,
  input  logic [1:0]                  l2_rvalid_i,
  input  logic [2*DataWidth-1:0]      l2_rdata_i
);

  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(2 * MaxOutstanding + 1);

  logic [AddrWidth-1:0]   addr  [NumReq];
  logic [DataWidth-1:0]   wdata [NumReq];
  logic [BeW-1:0]         be    [NumReq];
  l2_port_e               dec   [NumReq];
  logic [1:0][NumReq-1:0] elig;
  logic [NumReq-1:0]      elig_err;
  logic [CntW-1:0]        cnt_q [NumReq];
  logic [NumReq-1:0]      last_q;
  logic                   err_vld_q, err_acc;
  logic [IdW-1:0]         err_id_q, err_id;
  logic [1:0]             hs, pop;
  logic [IdW-1:0]         win  [2];
  logic [IdW-1:0]         head [2];

  // A requester with traffic in flight may only keep using the port it last used.
  always_comb begin
    err_acc = 1'b0;
    err_id  = '0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      addr[r]     = req_addr_i[r*AddrWidth +: AddrWidth];
      wdata[r]    = req_wdata_i[r*DataWidth +: DataWidth];
      be[r]       = req_be_i[r*BeW +: BeW];
      dec[r]      = port_decode(64'(addr[r]), L2Port0Base, L2PortSize);
      elig[0][r]  = rst_ni && req_valid_i[r] && dec[r] == L2P0 && (cnt_q[r] == '0 || !last_q[r]);
      elig[1][r]  = rst_ni && req_valid_i[r] && dec[r] == L2P1 && (cnt_q[r] == '0 || last_q[r]);
      elig_err[r] = rst_ni && req_valid_i[r] && dec[r] == L2ERR && cnt_q[r] == '0 && !err_vld_q;
      if (!err_acc && elig_err[r]) begin
        err_acc = 1'b1;
        err_id  = IdW'(r);
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    carfield_l2_sched_port #(
      .NumReq        (NumReq),
      .MaxOutstanding(MaxOutstanding)
    ) u_port (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .elig_i  (elig[p]),
      .gnt_i   (l2_gnt_i[p]),
      .rvalid_i(l2_rvalid_i[p] && rst_ni),
      .req_o   (l2_req_o[p]),
      .winner_o(win[p]),
      .hs_o    (hs[p]),
      .pop_o   (pop[p]),
      .head_o  (head[p])
    );
  end

  always_comb begin
    l2_addr_o   = '0;
    l2_we_o     = '0;
    l2_wdata_o  = '0;
    l2_be_o     = '0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      if (l2_req_o[p]) begin
        l2_addr_o[p*OffW +: OffW] = OffW'(64'(addr[win[p]]) - L2Port0Base - 64'(p) * L2PortSize);
        l2_we_o[p]                = req_we_i[win[p]];
        l2_wdata_o[p*DataWidth +: DataWidth] = wdata[win[p]];
        l2_be_o[p*BeW +: BeW]     = be[win[p]];
      end
      if (hs[p])  req_ready_o[win[p]]  = 1'b1;
      if (pop[p]) rsp_valid_o[head[p]] = 1'b1;
    end
    if (err_acc) req_ready_o[err_id] = 1'b1;
    if (err_vld_q && rst_ni) rsp_valid_o[err_id_q] = 1'b1;
  end

  // Shared data bus: port 0 wins if both ports respond in the same cycle.
  assign rsp_rdata_o = pop[0] ? l2_rdata_i[0 +: DataWidth] :
                       pop[1] ? l2_rdata_i[DataWidth +: DataWidth] : '0;
  assign rsp_err_o   = err_vld_q && rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NumReq; r++) cnt_q[r] <= '0;
      last_q    <= '0;
      err_vld_q <= 1'b0;
      err_id_q  <= '0;
    end else begin
      for (int unsigned r = 0; r < NumReq; r++)
        cnt_q[r] <= cnt_q[r] + CntW'(req_ready_o[r]) - CntW'(rsp_valid_o[r]);
      for (int unsigned p = 0; p < 2; p++)
        if (hs[p]) last_q[win[p]] <= 1'(p);
      err_vld_q <= err_acc;
      err_id_q  <= err_id;
    end
  end

endmodule

// File: tb/tb_carfield_l2_dual_port_sched.sv
// Randomized bench for the dual-port L2 scheduler against a queue-based reference model.
module tb_carfield_l2_dual_port_sched;

  localparam int N = 4, AW = 48, DW = 64, BW = 8, OW = 21, MAXO = 4;
  localparam logic [63:0] P0 = 64'h7800_0000;
  localparam logic [63:0] SZ = 64'h0020_0000;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req_valid_i = '0, req_ready_o, req_we_i = '0, rsp_valid_o;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_wdata_i = '0;
  logic [N*BW-1:0] req_be_i = '0;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;
  logic [1:0]      l2_req_o, l2_gnt_i = '0, l2_we_o, l2_rvalid_i = '0;
  logic [2*OW-1:0] l2_addr_o;
  logic [2*DW-1:0] l2_wdata_o, l2_rdata_i = '0;
  logic [2*BW-1:0] l2_be_o;

  carfield_l2_dual_port_sched #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW),
    .L2Port0Base(P0), .L2PortSize(SZ), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .l2_req_o(l2_req_o), .l2_gnt_i(l2_gnt_i), .l2_addr_o(l2_addr_o), .l2_we_o(l2_we_o),
    .l2_wdata_o(l2_wdata_o), .l2_be_o(l2_be_o), .l2_rvalid_i(l2_rvalid_i), .l2_rdata_i(l2_rdata_i)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Requester-side stimulus state: a request is held until it is accepted.
  logic        act   [N];
  logic [63:0] a_addr[N];
  logic        a_we  [N];
  logic [63:0] a_wd  [N];
  logic [7:0]  a_be  [N];

  // Reference model state.
  int q [2][$];
  int cnt [N], last [N], ptr [2];
  int errv, errid;

  int p_new = 0, p_gnt = 0, p_rv = 0, amode = 0;
  logic rst_cmd = 1'b0;

  function automatic int decode(input logic [63:0] a);
    if (a >= P0 && a < P0 + SZ) return 0;
    if (a >= P0 + SZ && a < P0 + 2 * SZ) return 1;
    return 2;
  endfunction

  function automatic logic [63:0] gen_addr(input int mode);
    logic [63:0] off;
    int k;
    off = 64'($urandom_range(32'(SZ / 8 - 1))) * 8;
    if ($urandom_range(7) == 0) off = ($urandom_range(1) == 1) ? 64'd0 : SZ - 8;
    if (mode == 1) k = 0;
    else if (mode == 2) k = ($urandom_range(3) == 0) ? int'($urandom_range(1)) : 2;
    else k = int'($urandom_range(5)) / 2;
    case (k)
      0: return P0 + off;
      1: return P0 + SZ + off;
      default: case ($urandom_range(3))
        0: return 64'h1000_0000;
        1: return P0 - 8;
        2: return P0 + 2 * SZ;
        default: return 64'h1_7800_0000 + off;
      endcase
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin q[p].delete(); ptr[p] = 0; end
    for (int r = 0; r < N; r++) begin cnt[r] = 0; last[r] = 0; end
    errv = 0; errid = 0;
  endtask

  task automatic step();
    int dec [N];
    int win [2], head [2];
    logic [1:0] ereq, ehs, pop;
    logic [N-1:0] exp_rdy, exp_rsp;
    logic [63:0] exp_rd;
    int e_acc;

    @(negedge clk);
    rst_ni = rst_cmd;
    for (int r = 0; r < N; r++) begin
      if (!act[r] && int'($urandom_range(99)) < p_new) begin
        act[r] = 1'b1; a_addr[r] = gen_addr(amode); a_we[r] = 1'($urandom);
        a_wd[r] = {$urandom, $urandom}; a_be[r] = 8'($urandom);
      end
      req_valid_i[r] = act[r];
      req_addr_i[r*AW +: AW] = a_addr[r][AW-1:0];
      req_we_i[r] = a_we[r];
      req_wdata_i[r*DW +: DW] = a_wd[r];
      req_be_i[r*BW +: BW] = a_be[r];
    end
    for (int p = 0; p < 2; p++) begin
      l2_gnt_i[p] = int'($urandom_range(99)) < p_gnt;
      l2_rvalid_i[p] = int'($urandom_range(99)) < p_rv;
      l2_rdata_i[p*DW +: DW] = {$urandom, $urandom};
    end
    #1;

    if (!rst_ni) begin
      check("rst_ready", 64'(req_ready_o), 0);
      check("rst_rsp_valid", 64'(rsp_valid_o), 0);
      check("rst_rsp_err", 64'(rsp_err_o), 0);
      check("rst_l2_req", 64'(l2_req_o), 0);
      check("rst_l2_addr", 64'(l2_addr_o), 0);
      model_reset();
      return;
    end

    for (int r = 0; r < N; r++) dec[r] = decode(a_addr[r]);
    exp_rdy = '0; exp_rsp = '0;
    for (int p = 0; p < 2; p++) begin
      win[p] = -1;
      for (int k = 0; k < N; k++) begin
        int r;
        r = (ptr[p] + k) % N;
        if (win[p] < 0 && act[r] && dec[r] == p && (cnt[r] == 0 || last[r] == p)) win[p] = r;
      end
      ereq[p] = (win[p] >= 0) && (q[p].size() < MAXO);
      ehs[p]  = ereq[p] && l2_gnt_i[p];
      if (ehs[p]) exp_rdy[win[p]] = 1'b1;
      pop[p]  = l2_rvalid_i[p] && (q[p].size() > 0);
      head[p] = pop[p] ? q[p][0] : 0;
      if (pop[p]) exp_rsp[head[p]] = 1'b1;
    end
    e_acc = -1;
    if (errv == 0)
      for (int r = 0; r < N; r++)
        if (e_acc < 0 && act[r] && dec[r] == 2 && cnt[r] == 0) e_acc = r;
    if (e_acc >= 0) exp_rdy[e_acc] = 1'b1;
    if (errv != 0) exp_rsp[errid] = 1'b1;
    exp_rd = pop[0] ? l2_rdata_i[0 +: DW] : pop[1] ? l2_rdata_i[DW +: DW] : 64'd0;

    check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp));
    check("l2_req", 64'(l2_req_o), 64'(ereq));
    for (int p = 0; p < 2; p++)
      if (ereq[p]) begin
        check($sformatf("l2_addr%0d", p), 64'(l2_addr_o[p*OW +: OW]),
              (a_addr[win[p]] - P0 - 64'(p) * SZ) & ((64'd1 << OW) - 1));
        check($sformatf("l2_we%0d", p), 64'(l2_we_o[p]), 64'(a_we[win[p]]));
        check($sformatf("l2_wdata%0d", p), l2_wdata_o[p*DW +: DW], a_wd[win[p]]);
        check($sformatf("l2_be%0d", p), 64'(l2_be_o[p*BW +: BW]), 64'(a_be[win[p]]));
      end
    if ($countones(exp_rsp) == 1) begin
      check("rsp_err", 64'(rsp_err_o), 64'(errv != 0));
      check("rsp_rdata", rsp_rdata_o, exp_rd);
    end

    for (int p = 0; p < 2; p++) begin
      if (pop[p]) begin cnt[head[p]]--; void'(q[p].pop_front()); end
      if (ehs[p]) begin
        q[p].push_back(win[p]); cnt[win[p]]++; last[win[p]] = p; ptr[p] = (win[p] + 1) % N;
      end
    end
    if (errv != 0) cnt[errid]--;
    errv = (e_acc >= 0); errid = (e_acc >= 0) ? e_acc : 0;
    if (e_acc >= 0) cnt[e_acc]++;
    for (int r = 0; r < N; r++) if (exp_rdy[r]) act[r] = 1'b0;
  endtask

  task automatic run(input int cycles, input int mode, input int pn, input int pg, input int pr);
    amode = mode; p_new = pn; p_gnt = pg; p_rv = pr;
    repeat (cycles) step();
  endtask

  initial begin
    for (int r = 0; r < N; r++) begin
      act[r] = 1'b0; a_addr[r] = '0; a_we[r] = 1'b0; a_wd[r] = '0; a_be[r] = '0;
    end
    model_reset();
    rst_cmd = 1'b0;
    run(2, 0, 50, 50, 50);
    rst_cmd = 1'b1;
    run(400, 0, 40, 60, 50);
    run(100, 1, 100, 100, 100);
    run(20, 1, 100, 100, 0);
    run(40, 1, 100, 100, 30);
    run(10, 0, 100, 100, 0);
    rst_cmd = 1'b0;
    run(1, 0, 100, 100, 0);
    rst_cmd = 1'b1;
    run(20, 0, 0, 100, 100);
    run(200, 2, 60, 70, 60);
    run(300, 0, 50, 50, 50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
